// File: rtl/cmult_pkg.sv
// Shared constants and types for the streaming complex multiplier.
package cmult_pkg;

  localparam int CM_A_W = 16;
  localparam int CM_B_W = 18;

  // Full-precision width of one complex product component.
  function automatic int cm_p_w(input int a, input int b);
    return a + b + 1;
  endfunction

  localparam int CM_P_W = cm_p_w(CM_A_W, CM_B_W);

  // Stage payload at the default operand widths.
  typedef struct packed {
    logic signed [CM_P_W-1:0] re;
    logic signed [CM_P_W-1:0] im;
    logic                     conj;
    logic                     ovf;
  } cm_payload_t;

endpackage

// File: rtl/cmult_round_sat.sv
// Combinational round-half-up, arithmetic shift and clamp of one
// full-precision component down to OUT_W bits, with a clamp flag.
module cmult_round_sat
  import cmult_pkg::*;
#(
  parameter int IN_W  = CM_P_W,
  parameter int OUT_W = CM_P_W,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    ovf
);

  // One extra bit so the rounding constant can never wrap.
  localparam int EW     = IN_W + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [EW-1:0] RND_C =
    (SHIFT > 0) ? (EW'(1) <<< RND_SH) : '0;
  localparam logic signed [EW-1:0] MAX_V = (EW'(1) <<< (OUT_W - 1)) - EW'(1);
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

  function automatic logic signed [EW-1:0] round_fn(input logic signed [IN_W-1:0] v);
    logic signed [EW-1:0] t;
    t = {v[IN_W-1], v};
    return (t + RND_C) >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_fn(input logic signed [EW-1:0] r);
    if (r > MAX_V) return MAX_V[OUT_W-1:0];
    if (r < MIN_V) return MIN_V[OUT_W-1:0];
    return r[OUT_W-1:0];
  endfunction

  logic signed [EW-1:0] r;

  // Round, then clamp to the output range and flag any clamp.
  always_comb begin
    r   = round_fn(x);
    y   = sat_fn(r);
    ovf = (r > MAX_V) || (r < MIN_V);
  end

endmodule

// File: rtl/cmult_stream.sv
// Four-stage pipelined signed complex multiplier with valid/ready flow
// control, per-sample conjugation of b and scaled/saturated outputs.
module cmult_stream
  import cmult_pkg::*;
#(
  parameter int A_W   = CM_A_W,
  parameter int B_W   = CM_B_W,
  parameter int OUT_W = cm_p_w(CM_A_W, CM_B_W),
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_conj,
  input  logic signed [A_W-1:0]   real_part_a,
  input  logic signed [A_W-1:0]   imag_part_a,
  input  logic signed [B_W-1:0]   real_part_b,
  input  logic signed [B_W-1:0]   imag_part_b,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] real_output,
  output logic signed [OUT_W-1:0] imag_output,
  output logic                    m_ovf,
  output logic                    ovf_sticky
);

  localparam int P_W = cm_p_w(A_W, B_W);

  logic adv;
  logic vld_p0, vld_p1, vld_p2, vld_p3;

  logic signed [A_W-1:0] ar_p0, ai_p0;
  logic signed [B_W-1:0] br_p0, bi_p0;
  logic                  conj_p0;

  logic signed [B_W:0]   bi_ext, bi_sel;
  logic signed [P_W-1:0] ar_x, ai_x, br_x, bi_x;

  logic signed [P_W-1:0] rr_p1, ii_p1, ri_p1, ir_p1;
  logic signed [P_W-1:0] re_p2, im_p2;

  logic signed [OUT_W-1:0] re_rs, im_rs;
  logic                    ovf_re, ovf_im;
  logic signed [OUT_W-1:0] re_p3, im_p3;
  logic                    ovf_p3;

  // Single global advance: every stage moves together or holds together.
  assign adv     = !vld_p3 || m_ready;
  assign s_ready = adv;
  assign m_valid = vld_p3;

  // Output data is forced to zero whenever no sample is being presented.
  assign real_output = vld_p3 ? re_p3 : '0;
  assign imag_output = vld_p3 ? im_p3 : '0;
  assign m_ovf       = vld_p3 && ovf_p3;

  // ---- S0: input register ----
  always_ff @(posedge clk) begin
    if (adv) begin
      ar_p0   <= real_part_a;
      ai_p0   <= imag_part_a;
      br_p0   <= real_part_b;
      bi_p0   <= imag_part_b;
      conj_p0 <= s_conj;
    end
  end

  // Conjugation in B_W+1 bits keeps -(-2^(B_W-1)) exact; all operands are
  // sign-extended to full precision so no product can wrap.
  always_comb begin
    bi_ext = {bi_p0[B_W-1], bi_p0};
    bi_sel = conj_p0 ? -bi_ext : bi_ext;
    ar_x   = {{(P_W-A_W){ar_p0[A_W-1]}}, ar_p0};
    ai_x   = {{(P_W-A_W){ai_p0[A_W-1]}}, ai_p0};
    br_x   = {{(P_W-B_W){br_p0[B_W-1]}}, br_p0};
    bi_x   = {{(P_W-B_W-1){bi_sel[B_W]}}, bi_sel};
  end

  // ---- S1: four partial products ----
  always_ff @(posedge clk) begin
    if (adv) begin
      rr_p1 <= ar_x * br_x;
      ii_p1 <= ai_x * bi_x;
      ri_p1 <= ar_x * bi_x;
      ir_p1 <= ai_x * br_x;
    end
  end

  // ---- S2: combine into real and imaginary parts ----
  always_ff @(posedge clk) begin
    if (adv) begin
      re_p2 <= rr_p1 - ii_p1;
      im_p2 <= ri_p1 + ir_p1;
    end
  end

  cmult_round_sat #(.IN_W(P_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs_re (
    .x   (re_p2),
    .y   (re_rs),
    .ovf (ovf_re)
  );

  cmult_round_sat #(.IN_W(P_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs_im (
    .x   (im_p2),
    .y   (im_rs),
    .ovf (ovf_im)
  );

  // ---- S3: rounded/saturated output register ----
  always_ff @(posedge clk) begin
    if (adv) begin
      re_p3  <= re_rs;
      im_p3  <= im_rs;
      ovf_p3 <= ovf_re || ovf_im;
    end
  end

  // Valid chain; reset discards every in-flight sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= s_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // Sticky flag records any saturated sample actually handed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (vld_p3 && m_ready && ovf_p3) begin
      ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmult_stream.sv
// Directed and streaming checks of cmult_stream at full precision and at
// OUT_W=24 / SHIFT=8, sharing one stimulus stream.
module tb_cmult_stream;

  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_conj, m_ready;
  logic signed [15:0] ar, ai;
  logic signed [17:0] br, bi;

  logic s_ready0, s_ready1, m_valid0, m_valid1, m_ovf0, m_ovf1, stk0, stk1;
  logic signed [34:0] re0, im0;
  logic signed [23:0] re1, im1;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  cmult_stream u0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_conj(s_conj),
    .real_part_a(ar), .imag_part_a(ai), .real_part_b(br), .imag_part_b(bi),
    .m_valid(m_valid0), .m_ready(m_ready), .real_output(re0), .imag_output(im0),
    .m_ovf(m_ovf0), .ovf_sticky(stk0)
  );

  cmult_stream #(.OUT_W(24), .SHIFT(8)) u1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_conj(s_conj),
    .real_part_a(ar), .imag_part_a(ai), .real_part_b(br), .imag_part_b(bi),
    .m_valid(m_valid1), .m_ready(m_ready), .real_output(re1), .imag_output(im1),
    .m_ovf(m_ovf1), .ovf_sticky(stk1)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference rounding (half toward +inf) and saturation.
  function automatic longint rnd(input longint x, input int sh);
    if (sh == 0) return x;
    return (x + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  function automatic longint rs_val(input longint x, input int sh, input int ow);
    longint r, mx;
    r  = rnd(x, sh);
    mx = (64'sd1 <<< (ow - 1)) - 1;
    if (r > mx) return mx;
    if (r < -mx - 1) return -mx - 1;
    return r;
  endfunction

  function automatic logic rs_ovf(input longint x, input int sh, input int ow);
    longint r, mx;
    r  = rnd(x, sh);
    mx = (64'sd1 <<< (ow - 1)) - 1;
    return (r > mx) || (r < -mx - 1);
  endfunction

  task automatic drive(input longint a_r, input longint a_i, input longint b_r,
                       input longint b_i, input logic cj);
    ar     = 16'(a_r);
    ai     = 16'(a_i);
    br     = 18'(b_r);
    bi     = 18'(b_i);
    s_conj = cj;
  endtask

  // Present one sample, confirm it is not out early, and stop on the
  // negedge where it should be presented at the output.
  task automatic run_one(input longint a_r, input longint a_i, input longint b_r,
                         input longint b_i, input logic cj);
    @(negedge clk);
    drive(a_r, a_i, b_r, b_i, cj);
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("lat_early", m_valid0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid0", m_valid0, 1);
    chk("lat_valid1", m_valid1, 1);
  endtask

  longint q_re0[$], q_im0[$], q_re1[$], q_im1[$];
  logic   q_ov1[$];

  initial begin
    int     sent, got, cyc;
    logic   held, new_s, c_cj;
    longint h_re0, h_im0, h_re1, h_im1;
    longint c_ar, c_ai, c_br, c_bi, bip, x_re, x_im;
    logic signed [15:0] t16;
    logic signed [17:0] t18;

    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    drive(0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_m_valid", m_valid0, 0);
    chk("rst_m_ovf", m_ovf0, 0);
    chk("rst_sticky0", stk0, 0);
    chk("rst_sticky1", stk1, 0);
    chk("rst_s_ready", s_ready0, 1);
    chk("rst_re0", re0, 0);
    chk("rst_im1", im1, 0);

    // Basic product, then a two-cycle stall on it.
    run_one(3, 4, 5, -2, 1'b0);
    chk("t1_re0", re0, 23);
    chk("t1_im0", im0, 14);
    chk("t1_ovf0", m_ovf0, 0);
    chk("t1_re1", re1, 0);
    chk("t1_im1", im1, 0);
    m_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("hold_valid", m_valid0, 1);
    chk("hold_re0", re0, 23);
    chk("hold_im0", im0, 14);
    chk("hold_s_ready", s_ready0, 0);
    m_ready = 1'b1;

    run_one(3, 4, 5, -2, 1'b1);
    chk("conj_re0", re0, 7);
    chk("conj_im0", im0, 26);

    // Most negative operands: exact at full width, saturates when scaled.
    run_one(-32768, -32768, -131072, -131072, 1'b0);
    chk("big_re0", re0, 0);
    chk("big_im0", im0, 64'sd8589934592);
    chk("big_ovf0", m_ovf0, 0);
    chk("big_re1", re1, 0);
    chk("big_im1", im1, 8388607);
    chk("big_ovf1", m_ovf1, 1);
    chk("big_stk1_pre", stk1, 0);
    @(posedge clk);
    @(negedge clk);
    chk("big_stk1_post", stk1, 1);
    chk("big_stk0_post", stk0, 0);

    // Round-half-up at SHIFT=8.
    run_one(384, 0, 1, 0, 1'b0);
    chk("rnd_p384_re0", re0, 384);
    chk("rnd_p384", re1, 2);
    chk("rnd_p384_ovf", m_ovf1, 0);
    run_one(-384, 0, 1, 0, 1'b0);
    chk("rnd_m384", re1, -1);
    run_one(128, 0, 1, 0, 1'b0);
    chk("rnd_p128", re1, 1);
    run_one(-128, 0, 1, 0, 1'b0);
    chk("rnd_m128", re1, 0);
    chk("rnd_m128_im", im1, 0);

    // Random stream against the reference model with random backpressure.
    sent = 0; got = 0; cyc = 0; held = 1'b0; new_s = 1'b1;
    c_ar = 0; c_ai = 0; c_br = 0; c_bi = 0; c_cj = 1'b0;
    h_re0 = 0; h_im0 = 0; h_re1 = 0; h_im1 = 0;
    while (got < 20 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        chk("stall_valid", m_valid0, 1);
        chk("stall_re0", re0, h_re0);
        chk("stall_im0", im0, h_im0);
        chk("stall_re1", re1, h_re1);
        chk("stall_im1", im1, h_im1);
      end
      m_ready = ($urandom_range(0, 2) != 0);
      if (sent < 20) begin
        if (new_s) begin
          t16 = 16'($urandom); c_ar = t16;
          t16 = 16'($urandom); c_ai = t16;
          t18 = 18'($urandom); c_br = t18;
          t18 = 18'($urandom); c_bi = t18;
          c_cj = 1'($urandom_range(0, 1));
          new_s = 1'b0;
        end
        drive(c_ar, c_ai, c_br, c_bi, c_cj);
        s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (m_valid0 && m_ready) begin
        chk("stream_extra", (q_re0.size() > 0), 1);
        if (q_re0.size() > 0) begin
          chk("stream_re0", re0, q_re0.pop_front());
          chk("stream_im0", im0, q_im0.pop_front());
          chk("stream_re1", re1, q_re1.pop_front());
          chk("stream_im1", im1, q_im1.pop_front());
          chk("stream_ovf1", m_ovf1, q_ov1.pop_front());
          chk("stream_ovf0", m_ovf0, 0);
        end
        got++;
      end
      held  = m_valid0 && !m_ready;
      h_re0 = re0; h_im0 = im0; h_re1 = re1; h_im1 = im1;
      if (s_valid && s_ready0) begin
        bip  = c_cj ? -c_bi : c_bi;
        x_re = c_ar * c_br - c_ai * bip;
        x_im = c_ar * bip + c_ai * c_br;
        q_re0.push_back(rs_val(x_re, 0, 35));
        q_im0.push_back(rs_val(x_im, 0, 35));
        q_re1.push_back(rs_val(x_re, 8, 24));
        q_im1.push_back(rs_val(x_im, 8, 24));
        q_ov1.push_back(rs_ovf(x_re, 8, 24) || rs_ovf(x_im, 8, 24));
        sent++;
        new_s = 1'b1;
      end
    end
    chk("stream_count", got, 20);
    chk("stream_drained", q_re0.size(), 0);
    s_valid = 1'b0;

    // Reset with samples in flight: nothing may emerge afterwards.
    @(negedge clk);
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(10 + k, k, 3, -1, 1'b0);
      s_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    chk("midrst_pre_valid", m_valid0, 1);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid0", m_valid0, 0);
    chk("midrst_valid1", m_valid1, 0);
    chk("midrst_re0", re0, 0);
    chk("midrst_stk1", stk1, 0);
    chk("midrst_s_ready1", s_ready1, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("midrst_no_stale", m_valid0, 0);
    end

    // Pipeline is usable again after the reset.
    run_one(3, 4, 5, -2, 1'b0);
    chk("post_re0", re0, 23);
    chk("post_im0", im0, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
